// File: rtl/mvb_discard_stats_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mvb_discard_stats_pkg
// Description : Shared constants and helpers for the MVB discard statistics
//               block: MI register word indices (MI_ADDR[4:2]), CTRL/STATUS
//               bit positions and the popcount function used by the counters.
// Revision    : 1.0 - initial release
// ============================================================================
package mvb_discard_stats_pkg;

  // Widest region vector the popcount helper accepts.
  localparam int unsigned c_POP_MAX_W = 64;

  // Register word indices.
  localparam logic [2:0] c_REG_TOTAL_LO = 3'd0;
  localparam logic [2:0] c_REG_TOTAL_HI = 3'd1;
  localparam logic [2:0] c_REG_DISC_LO  = 3'd2;
  localparam logic [2:0] c_REG_DISC_HI  = 3'd3;
  localparam logic [2:0] c_REG_CTRL     = 3'd4;
  localparam logic [2:0] c_REG_STATUS   = 3'd5;

  // CTRL and STATUS bit positions.
  localparam int unsigned c_CTRL_SNAP_BIT  = 0;
  localparam int unsigned c_CTRL_CLR_BIT   = 1;
  localparam int unsigned c_STATUS_VLD_BIT = 0;

  function automatic logic [6:0] popcount(input logic [c_POP_MAX_W-1:0] v);
    logic [6:0] n;
    n = '0;
    for (int i = 0; i < c_POP_MAX_W; i++) begin
      n = n + {6'd0, v[i]};
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mvb_discard_stats_cnt.sv
`default_nettype none
// ============================================================================
// Module      : mvb_discard_stats_cnt
// Description : Two-stage item counter. Stage 1 registers the popcount of the
//               qualified item vector; stage 2 accumulates it into a wrapping
//               counter. o_cnt_next is the value the counter takes at the next
//               edge, so a snapshot taken now includes the pending increment.
// Ports       : clk, rst_n      - clock, async active-low reset
//               i_items         - per-region items to count this cycle
//               i_clear         - zero the accumulator at the next edge
//               o_cnt_next      - accumulator value including stage-2 result
// Revision    : 1.0 - initial release
// ============================================================================
module mvb_discard_stats_cnt
  import mvb_discard_stats_pkg::*;
#(
  parameter int REGIONS   = 4,
  parameter int CNT_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [REGIONS-1:0]   i_items,
  input  logic                 i_clear,
  output logic [CNT_WIDTH-1:0] o_cnt_next
);

  localparam int INC_W = $clog2(REGIONS + 1);

  logic [c_POP_MAX_W-1:0] w_items_ext;
  logic [6:0]             w_pop_full;
  logic [INC_W-1:0]       w_pop;
  logic [INC_W-1:0]       r_inc;
  logic [CNT_WIDTH-1:0]   r_cnt;
  logic                   w_unused_pop;

  assign w_items_ext  = c_POP_MAX_W'(i_items);
  assign w_pop_full   = popcount(w_items_ext);
  assign w_pop        = w_pop_full[INC_W-1:0];
  assign w_unused_pop = ^w_pop_full;

  assign o_cnt_next = r_cnt + CNT_WIDTH'(r_inc);

  // On clear the accumulator restarts at zero; the increment registered in
  // the same edge is still added on the following edge, so items arriving
  // during the clear cycle are kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inc <= '0;
      r_cnt <= '0;
    end else begin
      r_inc <= w_pop;
      r_cnt <= i_clear ? '0 : o_cnt_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mvb_discard_stats.sv
`default_nettype none
// ============================================================================
// Module      : mvb_discard_stats
// Description : Counts MVB items and items flagged as discarded, with an MI
//               slave for snapshot/clear control and coherent snapshot readout.
// Ports       : CLK, RESET_N        - clock, async active-low reset
//               RX_MVB_*            - MVB sink (DATA = discard flag/region)
//               MI_*                - MI slave (snapshot regs, CTRL, STATUS)
// Revision    : 1.0 - initial release
// ============================================================================
module mvb_discard_stats
  import mvb_discard_stats_pkg::*;
#(
  parameter int REGIONS       = 4,
  parameter int CNT_WIDTH     = 64,
  parameter int MI_DATA_WIDTH = 32,
  parameter int MI_ADDR_WIDTH = 32
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic [REGIONS-1:0]       RX_MVB_DATA,
  input  logic [REGIONS-1:0]       RX_MVB_VLD,
  input  logic                     RX_MVB_SRC_RDY,
  output logic                     RX_MVB_DST_RDY,
  input  logic [MI_DATA_WIDTH-1:0] MI_DWR,
  input  logic [MI_ADDR_WIDTH-1:0] MI_ADDR,
  input  logic                     MI_RD,
  input  logic                     MI_WR,
  input  logic [3:0]               MI_BE,
  output logic [MI_DATA_WIDTH-1:0] MI_DRD,
  output logic                     MI_ARDY,
  output logic                     MI_DRDY
);

  logic                     r_run;
  logic [REGIONS-1:0]       w_items_total;
  logic [REGIONS-1:0]       w_items_disc;
  logic [CNT_WIDTH-1:0]     w_total_next;
  logic [CNT_WIDTH-1:0]     w_disc_next;
  logic [CNT_WIDTH-1:0]     r_snap_total;
  logic [CNT_WIDTH-1:0]     r_snap_disc;
  logic                     r_snap_vld;
  logic [2:0]               w_idx;
  logic                     w_ctrl_wr;
  logic                     w_snap;
  logic                     w_clr;
  logic [MI_DATA_WIDTH-1:0] w_rdata;
  logic [MI_DATA_WIDTH-1:0] r_drd;
  logic                     r_drdy;
  logic                     w_unused_mi;

  // r_run stays low for the first cycle after reset release, so items
  // presented while reset is being released are neither accepted nor counted.
  assign RX_MVB_DST_RDY = r_run;
  assign w_items_total  = RX_MVB_VLD & {REGIONS{RX_MVB_SRC_RDY & r_run}};
  assign w_items_disc   = w_items_total & RX_MVB_DATA;

  mvb_discard_stats_cnt #(
    .REGIONS   (REGIONS),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_cnt_total (
    .clk        (CLK),
    .rst_n      (RESET_N),
    .i_items    (w_items_total),
    .i_clear    (w_clr),
    .o_cnt_next (w_total_next)
  );

  mvb_discard_stats_cnt #(
    .REGIONS   (REGIONS),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_cnt_disc (
    .clk        (CLK),
    .rst_n      (RESET_N),
    .i_items    (w_items_disc),
    .i_clear    (w_clr),
    .o_cnt_next (w_disc_next)
  );

  // MI decode
  assign MI_ARDY     = MI_RD | MI_WR;
  assign w_idx       = MI_ADDR[4:2];
  assign w_ctrl_wr   = MI_WR & (w_idx == c_REG_CTRL) & MI_BE[0];
  assign w_snap      = w_ctrl_wr & MI_DWR[c_CTRL_SNAP_BIT];
  assign w_clr       = w_ctrl_wr & MI_DWR[c_CTRL_CLR_BIT];
  assign w_unused_mi = ^{MI_DWR, MI_BE, MI_ADDR};

  // Read mux sees only snapshot registers, so low/high halves always come
  // from the same capture, and a simultaneous write is not yet visible.
  always_comb begin
    w_rdata = '0;
    case (w_idx)
      c_REG_TOTAL_LO: w_rdata = r_snap_total[31:0];
      c_REG_TOTAL_HI: w_rdata = MI_DATA_WIDTH'(r_snap_total[CNT_WIDTH-1:32]);
      c_REG_DISC_LO:  w_rdata = r_snap_disc[31:0];
      c_REG_DISC_HI:  w_rdata = MI_DATA_WIDTH'(r_snap_disc[CNT_WIDTH-1:32]);
      c_REG_STATUS:   w_rdata[c_STATUS_VLD_BIT] = r_snap_vld;
      default:        w_rdata = '0;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_run        <= 1'b0;
      r_snap_total <= '0;
      r_snap_disc  <= '0;
      r_snap_vld   <= 1'b0;
      r_drd        <= '0;
      r_drdy       <= 1'b0;
    end else begin
      r_run  <= 1'b1;
      r_drdy <= MI_RD;
      r_drd  <= MI_RD ? w_rdata : '0;
      if (w_snap) begin
        r_snap_total <= w_total_next;
        r_snap_disc  <= w_disc_next;
        r_snap_vld   <= 1'b1;
      end
    end
  end

  assign MI_DRD  = r_drd;
  assign MI_DRDY = r_drdy;

endmodule
`default_nettype wire

// File: doc/mvb_discard_stats.md
MVB_DISCARD_STATS -- requirements
Module: mvb_discard_stats

Interface
REQ-001 Generic REGIONS, default 4, number of MVB items (regions) per word.
REQ-002 Generic CNT_WIDTH, default 64, statistics counter width; range 33..64.
REQ-003 Generic MI_DATA_WIDTH, default 32, MI data width; fixed 32.
REQ-004 Generic MI_ADDR_WIDTH, default 32, MI address width.
REQ-005 Port CLK  in  1  single clock for all logic.
REQ-006 Port RESET_N  in  1  asynchronous, active-low reset.
REQ-007 Port RX_MVB_DATA  in  REGIONS  per-region discard flag (1 = frame discarded by RX MAC Lite).
REQ-008 Port RX_MVB_VLD  in  REGIONS  per-region item valid.
REQ-009 Port RX_MVB_SRC_RDY  in  1  word valid.
REQ-010 Port RX_MVB_DST_RDY  out  1  sink ready; constant 1 outside reset.
REQ-011 Ports MI_DWR in 32, MI_ADDR in MI_ADDR_WIDTH, MI_RD in 1, MI_WR in 1, MI_BE in 4, MI_DRD out 32, MI_ARDY out 1, MI_DRDY out 1: MI slave for configuration and readout.

Function
REQ-012 Item counted when RX_MVB_SRC_RDY=1 and RX_MVB_VLD(i)=1; item counted as discarded when additionally RX_MVB_DATA(i)=1.
REQ-013 Stage 1 registers per-cycle popcounts inc_total and inc_disc (width clog2(REGIONS+1)); stage 2 adds them into CNT_TOTAL and CNT_DISC; an input word is visible in the counters 2 cycles after acceptance.
REQ-014 Counters wrap modulo 2^CNT_WIDTH; no saturation, no overflow flag.
REQ-015 Register map (byte address, MI_ADDR bits [4:2], upper bits ignored): 0x00 SNAP_TOTAL[31:0], 0x04 SNAP_TOTAL[CNT_WIDTH-1:32], 0x08 SNAP_DISC[31:0], 0x0C SNAP_DISC[CNT_WIDTH-1:32], 0x10 CTRL, 0x14 STATUS; unused upper bits read 0.
REQ-016 CTRL write with MI_BE(0)=1: bit0=1 copies live counters into snapshot registers (including stage-2 result of the same cycle); bit1=1 clears live counters; other bits and bytes ignored; CTRL reads 0.
REQ-017 Snapshot and clear in the same write: snapshot captures pre-clear value; live counter then holds only the stage-1 increment pending in that cycle (no counted item lost).
REQ-018 STATUS bit0 = snapshot valid (set by first snapshot, cleared by reset only); bits [31:1] read 0.
REQ-019 Reads return snapshot registers only, never live counters; 64-bit values are coherent across low/high reads.
REQ-020 MI_ARDY = MI_RD or MI_WR combinationally; every request accepted in one cycle.
REQ-021 MI_DRDY asserted exactly one cycle after an accepted MI_RD, for one cycle; MI_DRD registered, valid while MI_DRDY=1, 0 otherwise.
REQ-022 Unmapped address: read returns 0 with normal DRDY; write ignored.
REQ-023 MI_RD and MI_WR together: write performed, read answered with pre-write contents.
REQ-024 Back-to-back reads every cycle produce DRDY every cycle, in order.

Reset
REQ-025 RESET_N=0 asynchronously clears pipeline, live counters, snapshot registers, STATUS, MI_DRD and MI_DRDY to 0; RX_MVB_DST_RDY=0 during reset.
REQ-026 Items presented in the cycle RESET_N deasserts are not counted; counting starts the following cycle.
REQ-027 Reset mid-operation discards pending stage-1 increments.

Structure
REQ-028 Register offsets, CTRL/STATUS bit indices and the popcount function reside in shared package mvb_discard_stats_pkg.
REQ-029 One sub-module mvb_discard_stats_cnt (pipelined popcount + accumulator + clear) instantiated twice, total and discarded.

Verification
REQ-030 REGIONS=4, 10 words VLD=1111, DATA=0101, then snapshot, read -> TOTAL=40, DISC=20, STATUS=1.
REQ-031 Preload via 2^32-2 total items (force/backdoor), add 4 items, snapshot -> low=2, high=1.
REQ-032 Continuous traffic VLD=1111, DATA=1111; CTRL write 0x3 -> snapshot holds pre-clear count; next snapshot 5 cycles later shows DISC=TOTAL=20 or 24 per REQ-017 exact pipeline timing, no item lost across both snapshots.
REQ-033 SRC_RDY=0 with VLD=1111, DATA=1111 for 8 cycles -> counters unchanged (0).
REQ-034 Reads 0x00,0x04,0x18 back-to-back -> DRDY three consecutive cycles, 0x18 returns 0; RD+WR to 0x10 same cycle -> DRD=0, write effective.
REQ-035 RESET_N pulsed low mid-traffic -> all outputs 0 immediately, STATUS=0, counting resumes from 0.
